multicycle_control_unit: RTL



---
 rtl/multicycle_control_unit_pkg.sv | 69 ++++++
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/multicycle_control_unit_alu_decoder.sv | 49 ++++
 rtl/multicycle_control_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path:
// ALU op codes, FSM states, opcodes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LUI = 4'b1000,
        ALU_ORI = 4'b1001
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    // Which rule the ALU decoder applies in the current state.
    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_EXECR,
        CLS_EXECI,
        CLS_BRANCH,
        CLS_LUI
    } alu_cls_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control <-> datapath bundle: instruction fields and Zero in,
// enables, mux selects, ALU op, illegal pulse and state out.
interface multicycle_control_unit_if #(
    parameter int OP_W    = 4,
    parameter int STATE_W = 4
);
    logic [6:0]         Opcode_i;
    logic [2:0]         Funct3_i;
    logic               Funct7_b5_i;
    logic               Zero_i;
    logic               PC_Write_o;
    logic               IR_Write_o;
    logic               Mem_Write_o;
    logic               Reg_Write_o;
    logic               Adr_Src_o;
    logic [1:0]         Result_Src_o;
    logic [1:0]         ALU_Src_A_o;
    logic [1:0]         ALU_Src_B_o;
    logic [2:0]         Imm_Src_o;
    logic [OP_W-1:0]    ALU_Operation_o;
    logic               Illegal_Instr_o;
    logic [STATE_W-1:0] State_o;

    modport master (
        input  Opcode_i, Funct3_i, Funct7_b5_i, Zero_i,
        output PC_Write_o, IR_Write_o, Mem_Write_o,
        output Reg_Write_o, Adr_Src_o, Result_Src_o,
        output ALU_Src_A_o, ALU_Src_B_o, Imm_Src_o,
        output ALU_Operation_o, Illegal_Instr_o, State_o
    );

    modport slave (
        output Opcode_i, Funct3_i, Funct7_b5_i, Zero_i,
        input  PC_Write_o, IR_Write_o, Mem_Write_o,
        input  Reg_Write_o, Adr_Src_o, Result_Src_o,
        input  ALU_Src_A_o, ALU_Src_B_o, Imm_Src_o,
        input  ALU_Operation_o, Illegal_Instr_o, State_o
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: (class, funct3, funct7_b5) -> ALU op + illegal.
// Ports: cls, funct3, funct7_b5 in; alu_op, illegal out.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_cls_t    cls,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    output alu_op_t     alu_op,
    output logic        illegal
);
    logic is_r;

    assign is_r = (cls == CLS_EXECR);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        unique case (cls)
            CLS_SUB: alu_op = ALU_SUB;
            CLS_LUI: alu_op = ALU_LUI;
            CLS_BRANCH: begin
                alu_op  = ALU_SUB;
                // only beq (000) and bne (001)
                illegal = (funct3[2:1] != 2'b00);
            end
            CLS_EXECR, CLS_EXECI: begin
                unique case (funct3)
                    3'b000: begin
                        // addi ignores bit 30
                        if (is_r && funct7_b5) alu_op = ALU_SUB;
                        else                   alu_op = ALU_ADD;
                    end
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: illegal = 1'b1;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = ALU_SRL;
                    3'b110: begin
                        if (is_r) alu_op = ALU_OR;
                        else      alu_op = ALU_ORI;
                    end
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM (lw/sw/R/I/beq/bne/jal/lui).
// Ports: clk, reset (async, active-low), bus (master side).
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int STATE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);
    state_t     state, state_nxt;
    alu_cls_t   cls;
    alu_op_t    alu_op;
    logic       dec_ill;
    logic       opc_ill;
    logic       pc_w, ir_w, mem_w, reg_w, adr;
    logic [1:0] res, src_a, src_b;
    logic [2:0] imm;
    logic [6:0] opc;
    logic [2:0] f3;

    assign opc = bus.Opcode_i;
    assign f3  = bus.Funct3_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    alu_decoder u_alu_dec (
        .cls       (cls),
        .funct3    (f3),
        .funct7_b5 (bus.Funct7_b5_i),
        .alu_op    (alu_op),
        .illegal   (dec_ill)
    );

    always_comb begin
        state_nxt = S_FETCH;
        cls       = CLS_ADD;
        opc_ill   = 1'b0;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        adr       = 1'b0;
        res       = RES_ALUOUT;
        src_a     = SRC_A_PC;
        src_b     = SRC_B_RS2;
        imm       = IMM_I;
        unique case (state)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                src_b     = SRC_B_FOUR;
                res       = RES_ALU;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                src_a = SRC_A_OLDPC;
                src_b = SRC_B_IMM;
                unique case (opc)
                    OPC_LOAD: state_nxt = S_MEMADR;
                    OPC_STORE: begin
                        imm       = IMM_S;
                        state_nxt = S_MEMADR;
                    end
                    OPC_RTYPE: state_nxt = S_EXECR;
                    OPC_ITYPE: state_nxt = S_EXECI;
                    OPC_BRANCH: begin
                        imm       = IMM_B;
                        state_nxt = S_BRANCH;
                    end
                    OPC_JAL: begin
                        imm       = IMM_J;
                        state_nxt = S_JAL;
                    end
                    OPC_LUI: begin
                        imm       = IMM_U;
                        state_nxt = S_LUI;
                    end
                    default: opc_ill = 1'b1;
                endcase
            end
            S_MEMADR: begin
                src_a = SRC_A_RS1;
                src_b = SRC_B_IMM;
                if (opc == OPC_STORE) begin
                    imm       = IMM_S;
                    state_nxt = S_MEMWRITE;
                end else begin
                    state_nxt = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr       = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                res   = RES_MEMDATA;
                reg_w = 1'b1;
            end
            S_MEMWRITE: begin
                adr   = 1'b1;
                mem_w = 1'b1;
            end
            S_EXECR: begin
                cls   = CLS_EXECR;
                src_a = SRC_A_RS1;
                if (!dec_ill) state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                cls   = CLS_EXECI;
                src_a = SRC_A_RS1;
                src_b = SRC_B_IMM;
                if (!dec_ill) state_nxt = S_ALUWB;
            end
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                cls   = CLS_BRANCH;
                src_a = SRC_A_RS1;
                unique case (f3)
                    3'b000:  pc_w = bus.Zero_i;
                    3'b001:  pc_w = !bus.Zero_i;
                    default: pc_w = 1'b0;
                endcase
            end
            S_JAL: begin
                src_a     = SRC_A_OLDPC;
                src_b     = SRC_B_FOUR;
                pc_w      = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_LUI: begin
                cls       = CLS_LUI;
                src_b     = SRC_B_IMM;
                imm       = IMM_U;
                state_nxt = S_ALUWB;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs are held quiet while reset is low, even though the
    // state register already reads FETCH.
    always_comb begin
        bus.PC_Write_o      = reset & pc_w;
        bus.IR_Write_o      = reset & ir_w;
        bus.Mem_Write_o     = reset & mem_w;
        bus.Reg_Write_o     = reset & reg_w;
        bus.Adr_Src_o       = reset & adr;
        bus.Illegal_Instr_o = reset & (opc_ill | dec_ill);
        bus.Result_Src_o    = reset ? res   : 2'b00;
        bus.ALU_Src_A_o     = reset ? src_a : 2'b00;
        bus.ALU_Src_B_o     = reset ? src_b : 2'b00;
        bus.Imm_Src_o       = reset ? imm   : 3'b000;
        bus.ALU_Operation_o = reset ? OP_W'(alu_op) : '0;
        bus.State_o         = STATE_W'(state);
    end
endmodule
